button_event_arbiter: RTL and testbench

BUTTON_EVENT_ARBITER -- requirements
Module: button_event_arbiter

---
 rtl/button_event_arbiter_pkg.sv | 12 +
 rtl/button_event_arbiter_if.sv | 11 +
 rtl/button_event_arbiter_debounce.sv | 44 ++++
 rtl/button_event_arbiter.sv | 97 +++++++++
 tb/tb_button_event_arbiter.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/button_event_arbiter_pkg.sv
// Shared types and defaults for the button event arbiter.
package btn_arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_OFFER = 1'b1
  } arb_state_t;

  // 50 us of stability at a 20 ns clock
  localparam int DEFAULT_DELAY_VAL = 2500;

endpackage

// File: rtl/button_event_arbiter_if.sv
// Event handshake between the arbiter (master) and its consumer (slave).
interface btn_evt_if #(
  parameter int IDW = 2
) ();
  logic           evt_valid;
  logic           evt_ready;
  logic [IDW-1:0] evt_id;

  modport master (output evt_valid, output evt_id, input  evt_ready);
  modport slave  (input  evt_valid, input  evt_id, output evt_ready);
endinterface

// File: rtl/button_event_arbiter_debounce.sv
// One button channel: 2-flop synchroniser, stability counter, press pulse on stable 0->1.
module btn_debounce_ch
  import btn_arb_pkg::*;
#(
  parameter int DELAY_VAL = DEFAULT_DELAY_VAL
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press
);
  localparam int CW = $clog2(DELAY_VAL + 1);

  logic [1:0]    r_sync;
  logic          r_cand;
  logic          r_stable;
  logic          r_stable_d;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync     <= '0;
      r_cand     <= 1'b0;
      r_stable   <= 1'b0;
      r_stable_d <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_sync     <= {r_sync[0], btn_raw};
      r_stable_d <= r_stable;
      // Any change restarts the stability window; the counter parks at DELAY_VAL
      if (r_sync[1] != r_cand) begin
        r_cand <= r_sync[1];
        r_cnt  <= '0;
      end else if (r_cnt == CW'(DELAY_VAL)) begin
        r_stable <= r_cand;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign press = r_stable & ~r_stable_d;

endmodule

// File: rtl/button_event_arbiter.sv
// Debounced button press events, round-robin arbitrated onto a valid/ready handshake
// with per-channel sticky overrun flags.
module button_event_arbiter
  import btn_arb_pkg::*;
#(
  parameter int N_BTN     = 4,
  parameter int DELAY_VAL = DEFAULT_DELAY_VAL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] buttons,
  input  logic [N_BTN-1:0] enable_mask,
  input  logic             overrun_clr,
  output logic [N_BTN-1:0] overrun,
  btn_evt_if.master        evt
);
  localparam int IDW = $clog2(N_BTN);

  logic [N_BTN-1:0] w_press;
  logic [N_BTN-1:0] w_set;
  logic [N_BTN-1:0] w_clr;
  logic [N_BTN-1:0] r_pend;
  logic [N_BTN-1:0] r_overrun;
  logic [IDW-1:0]   r_evt_id;
  logic [IDW-1:0]   r_last_id;
  logic [IDW-1:0]   w_pick;
  logic             w_hit;
  logic             r_evt_valid;
  logic             w_accept;
  arb_state_t       r_state;
  arb_state_t       w_state_nxt;

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    btn_debounce_ch #(.DELAY_VAL(DELAY_VAL)) u_db (
      .clk     (clk),
      .rst     (rst),
      .btn_raw (buttons[g]),
      .press   (w_press[g])
    );
  end

  assign w_accept = r_evt_valid & evt.evt_ready;
  assign w_set    = w_press & enable_mask;

  always_comb begin
    w_clr = '0;
    if (w_accept) w_clr[r_evt_id] = 1'b1;
  end

  // Round-robin: first pending channel above the last one served, wrapping
  always_comb begin
    w_pick = '0;
    w_hit  = 1'b0;
    for (int k = 1; k <= N_BTN; k++) begin
      if (!w_hit && r_pend[(int'(r_last_id) + k) % N_BTN]) begin
        w_pick = IDW'((int'(r_last_id) + k) % N_BTN);
        w_hit  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ARB_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ARB_IDLE:  if (|r_pend)  w_state_nxt = ARB_OFFER;
      ARB_OFFER: if (w_accept) w_state_nxt = ARB_IDLE;
      default:                 w_state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_evt_valid <= 1'b0;
      r_evt_id    <= '0;
      r_last_id   <= IDW'(N_BTN - 1);
      r_pend      <= '0;
      r_overrun   <= '0;
    end else begin
      r_evt_valid <= (w_state_nxt == ARB_OFFER);
      if (r_state == ARB_IDLE && w_state_nxt == ARB_OFFER) r_evt_id <= w_pick;
      if (w_accept) r_last_id <= r_evt_id;
      // A press coinciding with its own acceptance re-arms pend without overrun
      r_pend    <= w_set | (r_pend & ~w_clr);
      r_overrun <= (w_set & r_pend & ~w_clr) | (overrun_clr ? '0 : r_overrun);
    end
  end

  assign evt.evt_valid = r_evt_valid;
  assign evt.evt_id    = r_evt_id;
  assign overrun       = r_overrun;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed and randomized checks of button_event_arbiter against a run-length/scoreboard model.
module tb_button_event_arbiter;
  localparam int N    = 4;
  localparam int D    = 4;
  localparam int IDW  = 2;
  localparam int HOLD = D + 2;   // consecutive raw samples needed to change the stable level

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] buttons = '0;
  logic [N-1:0] enable_mask = '1;
  logic         overrun_clr = 1'b0;
  logic [N-1:0] overrun;

  btn_evt_if #(.IDW(IDW)) evt ();

  button_event_arbiter #(.N_BTN(N), .DELAY_VAL(D)) dut (
    .clk         (clk),
    .rst         (rst),
    .buttons     (buttons),
    .enable_mask (enable_mask),
    .overrun_clr (overrun_clr),
    .overrun     (overrun),
    .evt         (evt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  bit           m_s1[N], m_s2[N], m_val[N], m_stab[N], m_pr[N];
  int           m_run[N];
  logic [N-1:0] m_pend, m_ovr;
  int           acc_cnt[N];
  int           acc_log[$];
  int           acc_cyc[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_s1[i] = 0; m_s2[i] = 0; m_val[i] = 0; m_stab[i] = 0; m_pr[i] = 0;
      m_run[i] = HOLD;
    end
    m_pend = '0;
    m_ovr  = '0;
  endtask

  task automatic clear_log();
    for (int i = 0; i < N; i++) acc_cnt[i] = 0;
    acc_log.delete();
    acc_cyc.delete();
  endtask

  task automatic tick();
    logic [N-1:0] raw, msk;
    logic acc, clr;
    int aid;
    bit seen, ns, set, cl;
    raw = buttons; msk = enable_mask; clr = overrun_clr;
    acc = evt.evt_valid && evt.evt_ready;
    aid = int'(evt.evt_id);
    if (acc && !rst) begin
      chk("accept_pending", m_pend[aid], 1);
      acc_cnt[aid]++;
      acc_log.push_back(aid);
      acc_cyc.push_back(cyc);
    end
    @(posedge clk);
    cyc++;
    if (rst) model_reset();
    else begin
      for (int i = 0; i < N; i++) begin
        seen = m_s2[i]; m_s2[i] = m_s1[i]; m_s1[i] = raw[i];
        if (seen == m_val[i]) begin
          if (m_run[i] < HOLD) m_run[i]++;
        end else begin
          m_val[i] = seen; m_run[i] = 1;
        end
        ns  = (m_run[i] >= HOLD) ? m_val[i] : m_stab[i];
        set = m_pr[i] && msk[i];
        cl  = acc && (aid == i);
        if (set && m_pend[i] && !cl) m_ovr[i] = 1'b1;
        else if (clr)                m_ovr[i] = 1'b0;
        m_pend[i] = set ? 1'b1 : (cl ? 1'b0 : m_pend[i]);
        m_pr[i]   = ns && !m_stab[i];
        m_stab[i] = ns;
      end
    end
    #1;
    chk("overrun", overrun, m_ovr);
    if (evt.evt_valid) chk("offer_pending", m_pend[evt.evt_id], 1);
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic wait_valid(input int budget, output int edges);
    edges = 0;
    while (!evt.evt_valid && edges < budget) begin
      tick();
      edges++;
    end
    chk("wait_valid", evt.evt_valid, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1; buttons = '0; enable_mask = '1; overrun_clr = 1'b0; evt.evt_ready = 1'b0;
    model_reset();
    run(2);
    rst = 1'b0;
    clear_log();
  endtask

  int n;
  int dwell[N];

  initial begin
    evt.evt_ready = 1'b0;
    model_reset();
    #1;
    chk("rst_valid", evt.evt_valid, 0);
    chk("rst_id", evt.evt_id, 0);
    chk("rst_overrun", overrun, 0);
    run(2);

    // Clean press on channel 2: valid on edge D+6 after the sampling edge
    rst = 1'b0; clear_log();
    evt.evt_ready = 1'b1;
    buttons = 4'b0100;
    wait_valid(40, n);
    chk("press_latency", n, D + 6);
    chk("press_id", evt.evt_id, 2);
    run(20);
    buttons = '0;
    run(20);
    chk("ch2_count", acc_cnt[2], 1);
    chk("ch2_total", acc_log.size(), 1);

    // Short glitch rejected; bounce then hold gives one event
    clear_log();
    buttons[1] = 1'b1; run(3);
    buttons[1] = 1'b0; run(20);
    chk("glitch_no_event", acc_log.size(), 0);
    buttons[1] = 1'b1; run(1);
    buttons[1] = 1'b0; run(1);
    buttons[1] = 1'b1; run(10);
    buttons = '0; run(20);
    chk("bounce_ch1", acc_cnt[1], 1);
    chk("bounce_total", acc_log.size(), 1);

    // Simultaneous presses after reset: round-robin from channel 0, one per 2 cycles
    do_reset();
    evt.evt_ready = 1'b1;
    buttons = 4'b1011;
    run(25);
    buttons = '0;
    run(15);
    chk("rr_total", acc_log.size(), 3);
    if (acc_log.size() == 3) begin
      chk("rr_id0", acc_log[0], 0);
      chk("rr_id1", acc_log[1], 1);
      chk("rr_id2", acc_log[2], 3);
      chk("rr_gap0", acc_cyc[1] - acc_cyc[0], 2);
      chk("rr_gap1", acc_cyc[2] - acc_cyc[1], 2);
    end

    // Stalled offer on channel 3, second press overruns, then clear
    clear_log();
    evt.evt_ready = 1'b0;
    buttons = 4'b1000;
    wait_valid(40, n);
    buttons = '0; run(HOLD + 4);
    buttons = 4'b1000; run(HOLD + 6);
    chk("ovr_set", overrun, 4'b1000);
    chk("ovr_id_held", evt.evt_id, 3);
    chk("ovr_valid_held", evt.evt_valid, 1);
    buttons = '0;
    evt.evt_ready = 1'b1;
    run(3);
    chk("ovr_one_delivered", acc_cnt[3], 1);
    overrun_clr = 1'b1; tick();
    overrun_clr = 1'b0;
    chk("ovr_cleared", overrun, 0);
    run(20);

    // Masked channel 0 is dropped
    clear_log();
    enable_mask = 4'b1110;
    buttons = 4'b0011;
    run(20);
    buttons = '0;
    run(15);
    chk("mask_ch1", acc_cnt[1], 1);
    chk("mask_total", acc_log.size(), 1);
    enable_mask = '1;

    // Reset during an offer
    clear_log();
    evt.evt_ready = 1'b0;
    buttons = 4'b0100;
    wait_valid(40, n);
    buttons = '0;
    #2 rst = 1'b1;
    #1;
    chk("midrst_valid", evt.evt_valid, 0);
    chk("midrst_id", evt.evt_id, 0);
    model_reset();
    run(2);
    rst = 1'b0;
    evt.evt_ready = 1'b1;
    run(30);
    chk("midrst_no_stale", acc_log.size(), 0);
    chk("midrst_idle", evt.evt_valid, 0);

    // Randomized traffic checked by the model every cycle
    do_reset();
    for (int i = 0; i < N; i++) dwell[i] = $urandom_range(20, 1);
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < N; i++) begin
        if (dwell[i] == 0) begin
          buttons[i] = ~buttons[i];
          dwell[i] = ($urandom_range(9) < 4) ? $urandom_range(4, 1) : $urandom_range(20, 8);
        end else begin
          dwell[i]--;
        end
      end
      evt.evt_ready = ($urandom_range(3) != 0);
      if ($urandom_range(49) == 0) enable_mask = N'($urandom);
      overrun_clr = ($urandom_range(29) == 0);
      tick();
    end
    buttons = '0; enable_mask = '1; overrun_clr = 1'b0; evt.evt_ready = 1'b1;
    run(40);
    chk("drain_pend", m_pend, 0);
    chk("drain_valid", evt.evt_valid, 0);
    chk("random_events_seen", acc_log.size() > 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
